wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, number of consecutive denied cycles after which requester B is granted ahead of A (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_reg  input  5  destination register of A.
REQ-006 a_data  input  32  write data of A.
REQ-007 a_ready  output  1  A's write accepted this cycle (combinational).
REQ-008 b_valid  input  1  requester B (load/multi-cycle unit) has a write pending.
REQ-009 b_reg  input  5  destination register of B.
REQ-010 b_data  input  32  write data of B.
REQ-011 b_ready  output  1  B's write accepted this cycle (combinational).
REQ-012 reg_write  output  1  write enable to the register bank, registered.
REQ-013 write_reg  output  5  register bank write address, registered.
REQ-014 write_data  output  32  register bank write data, registered.
REQ-015 starve  output  1  high while the wait counter equals MAX_WAIT (B forced priority).

Function
REQ-016 Transfer happens on a requester when its valid and ready are both high at a rising clk edge.
REQ-017 Grant rule each cycle: if b_valid and wait_cnt == MAX_WAIT, grant B; else if a_valid, grant A; else if b_valid, grant B; else no grant.
REQ-018 a_ready and b_ready SHALL never both be high; ready SHALL be low for a requester whose valid is low.
REQ-019 Ready depends only on current valids and wait_cnt, never on a_reg/b_reg/data.
REQ-020 wait_cnt (4 bits): +1 when b_valid high and B not granted, saturating at MAX_WAIT; cleared to 0 when B granted or b_valid low.
REQ-021 starve = (wait_cnt == MAX_WAIT).
REQ-022 Latency: a transfer at edge N drives reg_write=1, write_reg, write_data of the granted requester after edge N, valid for exactly one cycle unless another transfer follows.
REQ-023 Back-to-back transfers SHALL produce reg_write high on consecutive cycles with no bubble; throughput one write per cycle.
REQ-024 A transfer with destination register 0 SHALL be accepted (ready high) but SHALL produce reg_write=0 the next cycle; write_reg/write_data then hold previous values.
REQ-025 No transfer at an edge: reg_write=0 next cycle; write_reg/write_data hold previous values.
REQ-026 Both requesters targeting the same register in successive cycles: both writes issued in grant order; later write wins in the bank.
REQ-027 Requester must hold valid, reg and data stable until its ready; arbiter SHALL not buffer denied requests.

Reset
REQ-028 While rst high: reg_write=0, write_reg=0, write_data=0, wait_cnt=0, starve=0, asynchronously, independent of clk.
REQ-029 a_ready/b_ready SHALL be 0 while rst is high; a write in flight when rst asserts SHALL be discarded (no reg_write pulse after rst falls).
REQ-030 First grant possible at the first rising edge with rst low.

Verification
REQ-031 Single A: a_valid=1, a_reg=5, a_data=0x12345678 one cycle -> a_ready=1 same cycle; next cycle reg_write=1, write_reg=5, write_data=0x12345678; following cycle reg_write=0.
REQ-032 Contention: a_valid and b_valid held high, MAX_WAIT=4 -> A granted 4 cycles, B granted 5th (starve=1 that cycle), wait_cnt back to 0, A granted 6th.
REQ-033 Register 0: b_valid=1, b_reg=0, b_data=0xFFFFFFFF, a_valid=0 -> b_ready=1; next cycle reg_write=0, write_reg/write_data unchanged.
REQ-034 Back-to-back: A writes r1=0x1, r2=0x2, r3=0x3 on three consecutive cycles -> reg_write high three consecutive cycles with matching address/data in order.
REQ-035 Reset mid-operation: rst asserted asynchronously between edges while reg_write=1 and wait_cnt=3 -> reg_write, write_reg, write_data, wait_cnt, starve all 0 immediately, readys 0; no write after rst deasserts until a new transfer.
REQ-036 Random stimulus check: never both readys high; every accepted nonzero-reg transfer appears exactly once on the write port one cycle later.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write port arbiter: A (ALU) normally wins, but B
// is forced through once it has been denied MAX_WAIT consecutive cycles.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        starve
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        starve_w;
  logic        grant_a, grant_b;

  // Grants look only at valids and the wait count, so ready never depends on
  // register number or data; rst masks both so nothing is accepted in reset.
  assign starve_w = (wait_cnt_q == MaxWait);
  assign grant_b  = !rst && b_valid && (starve_w || !a_valid);
  assign grant_a  = !rst && a_valid && !(b_valid && starve_w);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wait_cnt_d   = wait_cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (!b_valid || grant_b) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Register 0 is hardwired: the transfer is consumed but the port stays idle.
    if (grant_a && (a_reg != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = a_reg;
      write_data_d = a_data;
    end else if (grant_b && (b_reg != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = b_reg;
      write_data_d = b_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign starve     = starve_w;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector table plus reset and random sequences for wb_port_arbiter
// with MAX_WAIT = 4.
module tb_wb_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, reg_write, starve;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .starve(starve)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        ea_rdy;
    logic        eb_rdy;
    logic        e_starve;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd,
                              input logic ea, input logic eb, input logic es,
                              input logic erw, input logic [4:0] ewr, input logic [31:0] ewd);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.ea_rdy = ea; v.eb_rdy = eb; v.e_starve = es;
    v.e_rw = erw; v.e_wr = ewr; v.e_wd = ewd;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  initial begin
    logic        pa_v, pb_v, ga, gb, exp_rw;
    logic [4:0]  pa_r, pb_r, exp_wr;
    logic [31:0] pa_d, pb_d, exp_wd;
    int          m_wait;

    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    #2;
    check("reset_reg_write", reg_write, 0);
    check("reset_write_reg", write_reg, 0);
    check("reset_write_data", write_data, 0);
    check("reset_starve", starve, 0);
    check("reset_readys", {a_ready, b_ready}, 0);
    @(posedge clk); #1;
    check("reset_hold_reg_write", reg_write, 0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;

    //        A: v  reg   data           B: v  reg   data          a  b  st  rw reg   data
    vecs.push_back(mk(1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd5, 32'h12345678));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd5, 32'h12345678));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 1, 0,  0, 5'd5, 32'h12345678));
    vecs.push_back(mk(1, 5'd1, 32'h1,        0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd1, 32'h1));
    vecs.push_back(mk(1, 5'd2, 32'h2,        0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd2, 32'h2));
    vecs.push_back(mk(1, 5'd3, 32'h3,        0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd3, 32'h3));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 1, 0, 0,  1, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 1, 0, 0,  1, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 1, 0, 0,  1, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 1, 0, 0,  1, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 0, 1, 1,  1, 5'd9, 32'hB0B0B0B0));
    vecs.push_back(mk(1, 5'd7, 32'hA0A0A0A0, 1, 5'd9, 32'hB0B0B0B0, 1, 0, 0,  1, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd7, 32'hA0A0A0A0));
    vecs.push_back(mk(1, 5'd4, 32'hAAAA,     1, 5'd4, 32'hBBBB,     1, 0, 0,  1, 5'd4, 32'hAAAA));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd4, 32'hBBBB,     0, 1, 0,  1, 5'd4, 32'hBBBB));
    vecs.push_back(mk(1, 5'd0, 32'hDEAD,     1, 5'd6, 32'h6666,     1, 0, 0,  0, 5'd4, 32'hBBBB));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd6, 32'h6666,     0, 1, 0,  1, 5'd6, 32'h6666));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      #1;
      check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea_rdy);
      check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb_rdy);
      check($sformatf("v%0d_starve", i), starve, vecs[i].e_starve);
      @(posedge clk); #1;
      check($sformatf("v%0d_reg_write", i), reg_write, vecs[i].e_rw);
      check($sformatf("v%0d_write_reg", i), write_reg, vecs[i].e_wr);
      check($sformatf("v%0d_write_data", i), write_data, vecs[i].e_wd);
    end

    // Reset between edges while a write is on the port and wait count is 3.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'h11, 1'b1, 5'd11, 32'h22);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_reg_write", reg_write, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_reg_write", reg_write, 0);
    check("mid_rst_write_reg", write_reg, 0);
    check("mid_rst_write_data", write_data, 0);
    check("mid_rst_starve", starve, 0);
    check("mid_rst_readys", {a_ready, b_ready}, 0);
    @(posedge clk); #1;
    check("rst_edge_reg_write", reg_write, 0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_pulse", reg_write, 0);
    @(negedge clk);
    drive(1'b1, 5'd12, 32'h33, 1'b1, 5'd13, 32'h44);
    for (int k = 0; k < MW; k++) begin
      #1;
      check($sformatf("post_rst_a_grant%0d", k), {a_ready, b_ready, starve}, 3'b100);
      @(negedge clk);
    end
    #1;
    check("post_rst_b_forced", {a_ready, b_ready, starve}, 3'b011);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);

    // Random traffic: requests held stable until accepted.
    m_wait = 0;
    pa_v = 1'b0; pb_v = 1'b0;
    pa_r = '0; pb_r = '0; pa_d = '0; pb_d = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!pa_v) begin
        pa_v = ($urandom_range(0, 9) < 7);
        pa_r = 5'($urandom_range(0, 31));
        pa_d = $urandom;
      end
      if (!pb_v) begin
        pb_v = ($urandom_range(0, 9) < 6);
        pb_r = 5'($urandom_range(0, 31));
        pb_d = $urandom;
      end
      drive(pa_v, pa_r, pa_d, pb_v, pb_r, pb_d);
      gb = pb_v && ((m_wait == MW) || !pa_v);
      ga = pa_v && !(pb_v && (m_wait == MW));
      #1;
      check($sformatf("rnd%0d_readys", c), {a_ready, b_ready}, {ga, gb});
      if (a_ready && b_ready) check($sformatf("rnd%0d_both_ready", c), 1'b1, 1'b0);
      exp_rw = (ga && pa_r != 0) || (gb && pb_r != 0);
      exp_wr = ga ? pa_r : pb_r;
      exp_wd = ga ? pa_d : pb_d;
      @(posedge clk); #1;
      check($sformatf("rnd%0d_reg_write", c), reg_write, exp_rw);
      if (exp_rw) check($sformatf("rnd%0d_port", c), {write_reg, write_data}, {exp_wr, exp_wd});
      if (!pb_v || gb) m_wait = 0;
      else if (m_wait != MW) m_wait = m_wait + 1;
      if (ga) pa_v = 1'b0;
      if (gb) pb_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
